tcdm_resp_mem: RTL
==================

Name: tcdm_resp_mem

Overview:
- TCDM responder: the slave end of the req/gnt/r_valid XBAR_TCDM_BUS protocol that the FC core's instruction and data ports drive as initiators.
- Fronts a private word-addressed memory with byte-enable writes.
- Programmable wait states; returns an error opcode for accesses that are out of range or misaligned.
- Used as a local scratchpad or boot-ROM stand-in and as a protocol-accurate bus model for the FC data/instr masters.

Parameters:
- ADDR_WIDTH, 32, width of add_i
- DATA_WIDTH, 32, width of wdata_i/r_rdata_o (multiple of 8)
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- NUM_WORDS, 256, memory depth in DATA_WIDTH words (power of 2, ≥2)
- BASE_ADDR, 32'h1C00_0000, byte address of word 0 (aligned to NUM_WORDS*BE_WIDTH)
- WAIT_CYCLES, 0, extra cycles between grant and memory access (0..15)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high)
- req_i  in  1  request valid from initiator
- add_i  in  ADDR_WIDTH  byte address
- wen_i  in  1  1 = read, 0 = write (active-low write enable, TCDM convention)
- wdata_i  in  DATA_WIDTH  write data
- be_i  in  BE_WIDTH  byte enables
- gnt_o  out  1  request accepted this cycle
- r_valid_o  out  1  response valid (single-cycle pulse)
- r_rdata_o  out  DATA_WIDTH  read data
- r_opc_o  out  1  response error (1 = error)

Behaviour:
- Reset values (rst_i=1 at a clock edge): state IDLE, counter 0, r_valid_o=0, r_rdata_o=0, r_opc_o=0. gnt_o is forced 0 while rst_i=1. Memory contents are not reset.
- gnt_o = req_i & ~rst_i & (state==IDLE). Combinational; no dependency on add_i/wen_i.
- On grant (req_i & gnt_o), latch add/wen/wdata/be.
  - WAIT_CYCLES==0: access performed at this edge; r_valid_o=1 next cycle; state stays IDLE. Back-to-back grants every cycle; 1 transaction/cycle.
  - WAIT_CYCLES>0: state<=BUSY, cnt<=WAIT_CYCLES-1.
- BUSY: gnt_o=0.
  - cnt!=0: cnt decrements.
  - cnt==0: access performed from the latched request, r_valid_o=1 next cycle, state<=IDLE.
- Latency: r_valid_o asserts exactly WAIT_CYCLES+1 cycles after the grant cycle. A new grant may coincide with r_valid_o of the previous transaction.
- Throughput: one transaction per WAIT_CYCLES+1 cycles.
- Error check at access time: err = (add < BASE_ADDR) | (add >= BASE_ADDR+NUM_WORDS*BE_WIDTH) | (add[log2(BE_WIDTH)-1:0]!=0).
  - err=1: r_opc_o=1, r_rdata_o=0, no memory write.
- Word index = (add-BASE_ADDR) >> log2(BE_WIDTH), truncated to log2(NUM_WORDS) bits.
- Read (wen=1, no err): r_rdata_o = mem[idx], full word, be ignored. r_opc_o=0.
- Write (wen=0, no err): mem[idx] byte b updated iff be[b]=1. be=0 writes nothing but still responds. r_rdata_o=0, r_opc_o=0.
- Read-after-write to the same word in back-to-back transactions returns the new data (write completes before the next access).
- r_rdata_o/r_opc_o are held between responses. Initiators must sample them only when r_valid_o=1.
- Reset mid-operation: an in-flight BUSY transaction is dropped; no response and no write.
- req_i deasserted while not granted is legal (no stickiness required).
- Unknown state encoding returns to IDLE.

Decomposition:
- Package tcdm_resp_pkg:
  - state_e {IDLE, BUSY}
  - OPC_OK=1'b0, OPC_ERR=1'b1
  - request struct (add, wen, wdata, be)
- Sub-module tcdm_resp_sram: single-port synchronous array.
  - Inputs: en, we, be, idx, wdata. Output: registered rdata, 1-cycle latency, byte-write.
  - Top level holds the FSM, counter, range check and response registers.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF @0x1C000010 be=1111, then read the same address next cycle -> gnt both cycles; r_valid 1 cycle after each grant; read r_rdata=0xDEADBEEF, r_opc=0.
- Byte enables: write 0x11223344 be=1111, then 0xAABBCCDD be=0101, then read -> 0x11BB33DD.
- WAIT_CYCLES=3: continuous req_i with reads -> gnt every 4th cycle; r_valid exactly 4 cycles after each gnt; the new gnt coincides with r_valid.
- Errors:
  - read @0x1C000400 (NUM_WORDS=256) -> r_opc=1, r_rdata=0.
  - write @0x1C000002 -> r_opc=1, memory unchanged (verify by a subsequent read).
  - read @0x1BFFFFFC -> r_opc=1.
- Reset mid-op (WAIT_CYCLES=3): write granted, rst_i=1 one cycle later -> no r_valid, gnt_o=0 during reset; target word still holds its old value afterwards.
- Random req/wen/be/addr stream (10k transactions) vs. reference model -> every grant receives exactly one response in order, data and r_opc match.

Source files
------------

// File: rtl/tcdm_resp_pkg.sv
// rtl/tcdm_resp_pkg.sv - shared types and constants for the TCDM responder
package tcdm_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01
  } state_e;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;

endpackage

// File: rtl/tcdm_resp_sram.sv
// rtl/tcdm_resp_sram.sv - single-port byte-writable array, registered read, 1-cycle latency
module tcdm_resp_sram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned NUM_WORDS  = 256,
  parameter int unsigned IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents are deliberately not reset; rdata only moves on a read so it holds between accesses.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tcdm_resp_mem.sv
// rtl/tcdm_resp_mem.sv - TCDM slave: req/gnt/r_valid handshake, wait states, range/alignment errors
module tcdm_resp_mem
  import tcdm_resp_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           BE_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned           NUM_WORDS   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1C00_0000,
  parameter int unsigned           WAIT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  r_opc_o
);

  localparam int unsigned           OFF_W      = $clog2(BE_WIDTH);
  localparam int unsigned           IDX_W      = $clog2(NUM_WORDS);
  localparam logic [ADDR_WIDTH:0]   LO_L       = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0]   HI_L       = LO_L + (ADDR_WIDTH+1)'(NUM_WORDS * BE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BE_WIDTH - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
  } req_t;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t req_q, live_req, acc_req;
  logic acc_en, acc_err, grant;
  logic [IDX_W-1:0] acc_idx;
  logic [DATA_WIDTH-1:0] sram_rdata;
  logic r_valid_q, r_opc_q, rd_sel_q;

  assign gnt_o    = req_i & ~rst_i & (state_q == IDLE);
  assign grant    = gnt_o;
  assign live_req = '{add: add_i, wen: wen_i, wdata: wdata_i, be: be_i};

  // With no wait states the live request goes straight to the array; otherwise the latched copy.
  always_comb begin
    acc_en  = 1'b0;
    acc_req = req_q;
    if (WAIT_CYCLES == 0) begin
      acc_en  = grant;
      acc_req = live_req;
    end else begin
      acc_en  = (state_q == BUSY) && (cnt_q == 4'd0) && !rst_i;
    end
  end

  assign acc_err = ({1'b0, acc_req.add} < LO_L) | ({1'b0, acc_req.add} >= HI_L) |
                   (|(acc_req.add & ALIGN_MASK));
  assign acc_idx = IDX_W'((acc_req.add - BASE_ADDR) >> OFF_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant && (WAIT_CYCLES != 0)) begin
          state_d = BUSY;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      r_valid_q <= 1'b0;
      r_opc_q   <= OPC_OK;
      rd_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_valid_q <= acc_en;
      if (acc_en) begin
        r_opc_q  <= acc_err ? OPC_ERR : OPC_OK;
        rd_sel_q <= ~acc_err & acc_req.wen;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) req_q <= live_req;
  end

  tcdm_resp_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (acc_en & ~acc_err),
    .we_i    (~acc_req.wen),
    .be_i    (acc_req.be),
    .idx_i   (acc_idx),
    .wdata_i (acc_req.wdata),
    .rdata_o (sram_rdata)
  );

  // Writes and errors answer zero; the array output is only exposed after a good read.
  assign r_valid_o = r_valid_q;
  assign r_opc_o   = r_opc_q;
  assign r_rdata_o = rd_sel_q ? sram_rdata : '0;

endmodule
